// File: rtl/modexp_arbiter_if.sv
// Requester-side and engine-side signal bundle for the modular-exponent arbiter.
// The master modport is the arbiter; the slave modport is the requesters plus engine.
interface modexp_arbiter_if #(
   parameter int WIDTH = 16,
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]            req_in;
   logic [N_REQ-1:0][WIDTH-1:0] req_value_in;
   logic [N_REQ-1:0][WIDTH-1:0] req_modulus_in;
   logic [N_REQ-1:0][WIDTH-1:0] req_exponent_in;
   logic [N_REQ-1:0]            grant_out;
   logic [N_REQ-1:0]            done_out;
   logic                        error_out;
   logic [WIDTH-1:0]            result_out;
   logic                        busy_out;
   logic                        eng_ready_out;
   logic [WIDTH-1:0]            eng_value_out;
   logic [WIDTH-1:0]            eng_modulus_out;
   logic [WIDTH-1:0]            eng_exponent_out;
   logic                        eng_busy_in;
   logic                        eng_valid_in;
   logic [WIDTH-1:0]            eng_value_in;

   modport master (
      input  req_in, req_value_in, req_modulus_in, req_exponent_in,
      input  eng_busy_in, eng_valid_in, eng_value_in,
      output grant_out, done_out, error_out, result_out, busy_out,
      output eng_ready_out, eng_value_out, eng_modulus_out, eng_exponent_out
   );

   modport slave (
      output req_in, req_value_in, req_modulus_in, req_exponent_in,
      output eng_busy_in, eng_valid_in, eng_value_in,
      input  grant_out, done_out, error_out, result_out, busy_out,
      input  eng_ready_out, eng_value_out, eng_modulus_out, eng_exponent_out
   );
endinterface

// File: rtl/modexp_arbiter.sv
// Round-robin arbiter sharing one modular-exponent engine among N_REQ requesters,
// with a bounded wait that aborts an operation when the engine never answers.
module modexp_arbiter_checker #(
   parameter int N_REQ = 4
) (
   input logic             clk_in,
   input logic             rst_in,
   input logic [N_REQ-1:0] grant,
   input logic [N_REQ-1:0] done,
   input logic             error,
   input logic             ready,
   input logic             busy
);
   a_grant_onehot: assert property (@(posedge clk_in) disable iff (rst_in) $onehot0(grant));
   a_done_onehot:  assert property (@(posedge clk_in) disable iff (rst_in) $onehot0(done));
   a_error_done:   assert property (@(posedge clk_in) disable iff (rst_in) error |-> (|done));
   a_ready_busy:   assert property (@(posedge clk_in) disable iff (rst_in) ready |-> busy);
   a_ready_grant:  assert property (@(posedge clk_in) disable iff (rst_in) ready |-> (|grant));
endmodule

module modexp_arbiter #(
   parameter int WIDTH   = 16,
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 4096
) (
   input logic              clk_in,
   input logic              rst_in,
   modexp_arbiter_if.master bus
);
   localparam int               PTR_W    = $clog2(N_REQ);
   localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(N_REQ - 1);
   localparam logic [PTR_W:0]   N_WRAP   = (PTR_W + 1)'(N_REQ);
   localparam logic [N_REQ-1:0] REQ_ZERO = {N_REQ{1'b0}};
   localparam logic [N_REQ-1:0] REQ_ONE  = {{(N_REQ-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t           state_r;
   state_t           state_s;
   logic [PTR_W-1:0] ptr_r;
   logic [PTR_W-1:0] winner_s;
   logic             found_s;
   logic             launch_s;
   logic             complete_s;
   logic             expire_s;
   logic [CNT_W-1:0] cnt_r;
   logic [N_REQ-1:0] grant_r;
   logic [N_REQ-1:0] done_r;
   logic             error_r;
   logic             busy_r;
   logic             eng_ready_r;
   logic [WIDTH-1:0] result_r;
   logic [WIDTH-1:0] eng_value_r;
   logic [WIDTH-1:0] eng_modulus_r;
   logic [WIDTH-1:0] eng_exponent_r;

   // Round-robin pick: scanning from the farthest offset down lets the nearest requester after ptr_r win
   always_comb begin
      logic [PTR_W:0]   sum;
      logic [PTR_W-1:0] idx;
      sum      = {(PTR_W + 1){1'b0}};
      idx      = {PTR_W{1'b0}};
      winner_s = ptr_r;
      found_s  = 1'b0;
      for (int off = N_REQ; off >= 1; off--) begin
         sum      = {1'b0, ptr_r} + (PTR_W + 1)'(off);
         idx      = (sum >= N_WRAP) ? PTR_W'(sum - N_WRAP) : sum[PTR_W-1:0];
         winner_s = bus.req_in[idx] ? idx : winner_s;
         found_s  = found_s | bus.req_in[idx];
      end
   end

   // Next-state decode and the three transaction events
   always_comb begin
      state_s    = state_r;
      launch_s   = 1'b0;
      complete_s = 1'b0;
      expire_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (found_s && !bus.eng_busy_in) begin
               launch_s = 1'b1;
               state_s  = ST_ISSUE;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_ISSUE: state_s = ST_WAIT;
         ST_WAIT: begin
            // A result arriving on the last allowed cycle still counts as a success
            if (bus.eng_valid_in) begin
               complete_s = 1'b1;
               state_s    = ST_IDLE;
            end else if (cnt_r >= CNT_LAST) begin
               expire_s   = 1'b1;
               state_s    = ST_DRAIN;
            end else begin
               state_s    = ST_WAIT;
            end
         end
         ST_DRAIN: begin
            if (!bus.eng_busy_in && !bus.eng_valid_in) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // State register, round-robin pointer and wait counter
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_r <= ST_IDLE;
         ptr_r   <= PTR_INIT;
         cnt_r   <= CNT_ZERO;
      end else begin
         state_r <= state_s;
         if (launch_s) begin
            ptr_r <= winner_s;
         end
         if (state_r == ST_ISSUE) begin
            cnt_r <= CNT_ZERO;
         end else if (state_r == ST_WAIT && !bus.eng_valid_in && !expire_s) begin
            cnt_r <= cnt_r + CNT_ONE;
         end
      end
   end

   // Requester-facing outputs
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         grant_r  <= REQ_ZERO;
         done_r   <= REQ_ZERO;
         error_r  <= 1'b0;
         result_r <= W_ZERO;
         busy_r   <= 1'b0;
      end else begin
         busy_r  <= (state_s != ST_IDLE);
         error_r <= expire_s;
         done_r  <= (complete_s || expire_s) ? grant_r : REQ_ZERO;
         if (launch_s) begin
            grant_r <= REQ_ONE << winner_s;
         end else if (complete_s || expire_s) begin
            grant_r <= REQ_ZERO;
         end
         if (complete_s) begin
            result_r <= bus.eng_value_in;
         end else if (expire_s) begin
            result_r <= W_ZERO;
         end
      end
   end

   // Engine-facing outputs; operands are captured only at grant time
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         eng_ready_r    <= 1'b0;
         eng_value_r    <= W_ZERO;
         eng_modulus_r  <= W_ZERO;
         eng_exponent_r <= W_ZERO;
      end else begin
         eng_ready_r <= (state_r == ST_ISSUE);
         if (launch_s) begin
            eng_value_r    <= bus.req_value_in[winner_s];
            eng_modulus_r  <= bus.req_modulus_in[winner_s];
            eng_exponent_r <= bus.req_exponent_in[winner_s];
         end
      end
   end

   assign bus.grant_out        = grant_r;
   assign bus.done_out         = done_r;
   assign bus.error_out        = error_r;
   assign bus.result_out       = result_r;
   assign bus.busy_out         = busy_r;
   assign bus.eng_ready_out    = eng_ready_r;
   assign bus.eng_value_out    = eng_value_r;
   assign bus.eng_modulus_out  = eng_modulus_r;
   assign bus.eng_exponent_out = eng_exponent_r;

   modexp_arbiter_checker #(.N_REQ(N_REQ)) u_chk (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .grant  (grant_r),
      .done   (done_r),
      .error  (error_r),
      .ready  (eng_ready_r),
      .busy   (busy_r)
   );
endmodule

// File: tb/tb_modexp_arbiter.sv
// Scoreboard bench: stimulus pushes hand-computed completions, a monitor pops them on done_out.
// A behavioural engine answers eng_ready_out after a programmable latency.
module tb_modexp_arbiter;
   localparam int W  = 16;
   localparam int N  = 4;
   localparam int TO = 64;

   typedef struct packed {
      int idx;
      int result;
      int err;
   } exp_t;

   logic clk_in = 1'b0;
   logic rst_in = 1'b1;
   always #5 clk_in = ~clk_in;

   modexp_arbiter_if #(.WIDTH(W), .N_REQ(N)) bus ();

   modexp_arbiter #(.WIDTH(W), .N_REQ(N), .TIMEOUT(TO)) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus)
   );

   exp_t exp_q[$];
   int   errors   = 0;
   int   checks   = 0;
   int   n_ready  = 0;
   int   rem [N];
   bit   sim_done = 1'b0;

   int         lat        = 3;
   logic       hold_busy  = 1'b0;
   logic       kick       = 1'b0;
   logic       eng_busy_r = 1'b0;
   int         cd         = 0;
   logic [W-1:0] eng_res  = 16'd0;

   assign bus.eng_busy_in = eng_busy_r | hold_busy;

   function automatic logic [W-1:0] modexp(input logic [W-1:0] b, input logic [W-1:0] m, input logic [W-1:0] e);
      longint mm, r, x;
      mm = longint'(m);
      r  = 1 % mm;
      x  = longint'(b) % mm;
      for (int i = 0; i < W; i++) begin
         if (e[i]) r = (r * x) % mm;
         x = (x * x) % mm;
      end
      return W'(r);
   endfunction

   // Behavioural engine; lat==0 means it never answers
   always @(posedge clk_in) begin
      bus.eng_valid_in <= 1'b0;
      if (bus.eng_ready_out) begin
         eng_busy_r <= (lat != 0);
         cd         <= lat;
         eng_res    <= modexp(bus.eng_value_out, bus.eng_modulus_out, bus.eng_exponent_out);
      end else if (cd != 0) begin
         cd <= cd - 1;
         if (cd == 1) begin
            bus.eng_valid_in <= 1'b1;
            bus.eng_value_in <= eng_res;
            eng_busy_r       <= 1'b0;
         end
      end
      if (kick) begin
         bus.eng_valid_in <= 1'b1;
         bus.eng_value_in <= 16'hBEEF;
      end
   end

   task automatic check(input string name, input int act, input int expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic push_exp(input int i, input int r, input int e);
      exp_t x;
      x.idx    = i;
      x.result = r;
      x.err    = e;
      exp_q.push_back(x);
   endtask

   task automatic set_op(input int i, input int v, input int m, input int e);
      bus.req_value_in[i]    = W'(v);
      bus.req_modulus_in[i]  = W'(m);
      bus.req_exponent_in[i] = W'(e);
   endtask

   task automatic set_req(input int i, input int count);
      rem[i]        = count;
      bus.req_in[i] = (count > 0);
   endtask

   // Requesters keep req high until their remaining operation count is used up
   task automatic step();
      @(negedge clk_in);
      for (int i = 0; i < N; i++) begin
         if (bus.done_out[i] && rem[i] > 0) rem[i] = rem[i] - 1;
         bus.req_in[i] = (rem[i] > 0);
      end
   endtask

   task automatic wait_idle(input int budget);
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < budget) begin
         step();
         t++;
      end
      check("queue_drained", exp_q.size(), 0);
      step();
      step();
   endtask

   task automatic wait_ready(input int budget);
      int t;
      t = 0;
      while (!bus.eng_ready_out && t < budget) begin
         step();
         t++;
      end
      check("ready_seen", int'(bus.eng_ready_out), 1);
   endtask

   task automatic cycles_to_done(input int budget, output int t);
      t = 0;
      do begin
         step();
         t++;
      end while (bus.done_out == 4'd0 && t < budget);
   endtask

   task automatic do_reset();
      step();
      rst_in = 1'b1;
      for (int i = 0; i < N; i++) set_req(i, 0);
      step();
      step();
      rst_in = 1'b0;
   endtask

   initial begin
      bus.req_in          = 4'd0;
      bus.req_value_in    = 64'd0;
      bus.req_modulus_in  = 64'd0;
      bus.req_exponent_in = 64'd0;
      for (int i = 0; i < N; i++) rem[i] = 0;

      fork
         begin : stim
            int base;
            int t;
            step();
            step();
            step();
            check("rst_grant",   bus.grant_out, 0);
            check("rst_done",    bus.done_out, 0);
            check("rst_error",   bus.error_out, 0);
            check("rst_ready",   bus.eng_ready_out, 0);
            check("rst_busy",    bus.busy_out, 0);
            check("rst_result",  bus.result_out, 0);
            check("rst_eng_val", bus.eng_value_out, 0);
            check("rst_eng_mod", bus.eng_modulus_out, 0);
            check("rst_eng_exp", bus.eng_exponent_out, 0);
            rst_in = 1'b0;
            step();

            // Single request with grant/issue latency and operand isolation
            set_op(0, 4, 497, 13);
            push_exp(0, 445, 0);
            base = n_ready;
            set_req(0, 1);
            step();
            check("grant_after_k", bus.grant_out, 1);
            check("ready_not_yet", bus.eng_ready_out, 0);
            check("busy_on_grant", bus.busy_out, 1);
            check("eng_value",     bus.eng_value_out, 4);
            check("eng_modulus",   bus.eng_modulus_out, 497);
            check("eng_exponent",  bus.eng_exponent_out, 13);
            bus.req_value_in[0] = 16'd9;
            step();
            check("ready_after_k1", bus.eng_ready_out, 1);
            step();
            check("ready_one_cycle", bus.eng_ready_out, 0);
            wait_idle(100);
            check("single_ready_cnt", n_ready - base, 1);
            check("result_held",      bus.result_out, 445);
            check("idle_not_busy",    bus.busy_out, 0);

            // Round robin from reset: 0,1,2,3 then 0 again
            do_reset();
            set_op(0, 2, 1000, 10);
            set_op(1, 3, 7, 4);
            set_op(2, 5, 13, 3);
            set_op(3, 7, 10, 2);
            push_exp(0, 24, 0);
            push_exp(1, 4, 0);
            push_exp(2, 8, 0);
            push_exp(3, 9, 0);
            push_exp(0, 24, 0);
            set_req(0, 2);
            set_req(1, 1);
            set_req(2, 1);
            set_req(3, 1);
            wait_idle(400);

            // Fairness between two permanent requesters
            do_reset();
            set_op(0, 3, 100, 3);
            set_op(2, 10, 7, 2);
            push_exp(0, 27, 0);
            push_exp(2, 2, 0);
            push_exp(0, 27, 0);
            push_exp(2, 2, 0);
            set_req(0, 2);
            set_req(2, 2);
            wait_idle(400);

            // Requester drops req right after grant; operation still completes
            set_op(3, 2, 31, 5);
            push_exp(3, 1, 0);
            set_req(3, 1);
            t = 0;
            while (!bus.grant_out[3] && t < 20) begin
               step();
               t++;
            end
            check("grant3_seen", int'(bus.grant_out[3]), 1);
            set_req(3, 0);
            wait_idle(100);

            // Timeout with a hung engine, then drain behaviour
            lat = 0;
            set_op(1, 3, 7, 4);
            push_exp(1, 0, 1);
            set_req(1, 1);
            wait_ready(20);
            hold_busy = 1'b1;
            cycles_to_done(200, t);
            check("timeout_latency", t, 64);
            set_op(2, 10, 7, 2);
            set_req(2, 1);
            repeat (8) step();
            check("drain_no_grant", bus.grant_out, 0);
            check("drain_busy",     bus.busy_out, 1);
            kick = 1'b1;
            step();
            kick = 1'b0;
            step();
            step();
            check("drain_result_kept", bus.result_out, 0);
            check("drain_still_busy",  bus.busy_out, 1);
            lat = 3;
            push_exp(2, 2, 0);
            hold_busy = 1'b0;
            wait_idle(100);
            kick = 1'b1;
            step();
            kick = 1'b0;
            step();
            step();
            check("idle_valid_ignored", bus.result_out, 2);

            // Asynchronous reset in WAIT abandons the operation
            lat = 20;
            set_op(0, 4, 497, 13);
            set_req(0, 1);
            wait_ready(20);
            repeat (5) step();
            #2 rst_in = 1'b1;
            #1;
            check("arst_grant",   bus.grant_out, 0);
            check("arst_busy",    bus.busy_out, 0);
            check("arst_ready",   bus.eng_ready_out, 0);
            check("arst_result",  bus.result_out, 0);
            check("arst_eng_val", bus.eng_value_out, 0);
            check("arst_done",    bus.done_out, 0);
            set_req(0, 0);
            step();
            step();
            step();
            rst_in = 1'b0;
            set_op(1, 3, 7, 4);
            push_exp(1, 4, 0);
            set_req(1, 1);
            step();
            step();
            check("wait_engine_idle", bus.grant_out, 0);
            wait_idle(300);

            // Engine result lands exactly on the timeout cycle
            lat = 62;
            set_op(2, 5, 13, 3);
            push_exp(2, 8, 0);
            set_req(2, 1);
            wait_ready(20);
            cycles_to_done(200, t);
            check("simul_latency", t, 64);
            wait_idle(100);

            sim_done = 1'b1;
         end
         begin : monitor
            exp_t e;
            while (!sim_done) begin
               @(negedge clk_in);
               if (bus.eng_ready_out) n_ready++;
               if (bus.done_out != 4'd0) begin
                  if (exp_q.size() == 0) begin
                     check("unexpected_done", bus.done_out, 0);
                  end else begin
                     e = exp_q.pop_front();
                     check("done_index", bus.done_out, 1 << e.idx);
                     check("done_result", bus.result_out, e.result);
                     check("done_error", bus.error_out, e.err);
                  end
               end else if (bus.error_out) begin
                  check("error_without_done", bus.error_out, 0);
               end
            end
         end
      join

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
